// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer that fetches one word,
// holds it for decode until acknowledged, then advances pc (sequential/branch/jump).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        issue_ack,
  input  logic        Brn,
  input  logic        Bne,
  input  logic        jmp,
  input  logic        jal,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_d, valid_d;
  logic              load_instr, advance;
  logic [XLEN-1:0]   pc_q, instr_q, retired_q;
  logic [XLEN-1:0]   pc4, branch_off, branch_target, jump_target, next_pc;
  logic              take_branch;

  // Next-pc selection; jumps win over branches.
  always_comb begin
    pc4           = pc_q + XLEN'(4);
    branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_target = pc4 + branch_off;
    jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
    take_branch   = (Brn & zero) | (Bne & ~zero);
    if (jmp || jal) begin
      next_pc = jump_target;
    end else if (take_branch) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc4;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    valid_d    = 1'b0;
    load_instr = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        req_d = 1'b1;
        if (imem_ready) begin
          state_d    = ISSUE;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          load_instr = 1'b1;
        end
      end
      ISSUE: begin
        valid_d = 1'b1;
        if (issue_ack) begin
          state_d = FETCH;
          req_d   = 1'b1;
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_req    <= req_d;
      instr_valid <= valid_d;
    end
  end

  // Datapath: instruction capture, pc update and retirement count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      if (load_instr) begin
        instr_q <= imem_rdata;
      end
      if (advance) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + XLEN'(1);
      end
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign link_addr = pc4;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a driver walks a vector table while a
// monitor checks each fetch address and issued instruction against scoreboard queues.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_ready, instr_valid, issue_ack;
  logic [31:0] imem_addr, imem_rdata, instr, pc, link_addr, retired;
  logic [5:0]  opcode;
  logic        brn, bne, jmp, jal, zero;

  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, instr2, pc2, link_addr2, retired2;
  logic [5:0]  opcode2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          rdy_d;
    int          ack_d;
    logic        brn, bne, jmp, jal, zero;
    logic [31:0] next;
    logic        do_rst;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] link;
  } iss_t;

  logic [31:0] addr_q[$];
  iss_t        issue_q[$];
  vec_t        vecs[13];

  instr_fetch_unit u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .issue_ack(issue_ack), .Brn(brn), .Bne(bne),
    .jmp(jmp), .jal(jal), .zero(zero), .pc(pc), .link_addr(link_addr), .retired(retired)
  );

  // Second instance exercises the top-of-address-space wrap.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr2), .opcode(opcode2),
    .instr_valid(instr_valid2), .issue_ack(issue_ack), .Brn(brn), .Bne(bne),
    .jmp(jmp), .jal(jal), .zero(zero), .pc(pc2), .link_addr(link_addr2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on rising imem_req and rising instr_valid.
  initial begin : monitor
    logic req_prev, valid_prev;
    logic [31:0] exp_addr;
    iss_t exp_iss;
    req_prev = 1'b0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && !req_prev) begin
        if (addr_q.size() == 0) begin
          check("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
        end else begin
          exp_addr = addr_q.pop_front();
          check("fetch_addr", imem_addr, exp_addr);
        end
      end
      if (instr_valid && !valid_prev) begin
        if (issue_q.size() == 0) begin
          check("unexpected_issue", instr, 32'hDEAD_BEEF);
        end else begin
          exp_iss = issue_q.pop_front();
          check("issue_instr", instr, exp_iss.word);
          check("issue_opcode", 32'(opcode), 32'(exp_iss.word[31:26]));
          check("issue_link", link_addr, exp_iss.link);
        end
      end
      req_prev = imem_req;
      valid_prev = instr_valid;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) check("req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic clear_ctrl();
    brn = 1'b0; bne = 1'b0; jmp = 1'b0; jal = 1'b0; zero = 1'b0;
  endtask

  initial begin : driver
    vecs[0]  = '{32'h0000_0000, 32'h0043_1020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
    vecs[1]  = '{32'h0000_0004, 32'h0085_1822, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b0};
    vecs[2]  = '{32'h0000_0008, 32'h00A6_2025, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
    vecs[3]  = '{32'h0000_000C, 32'h0800_0040, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[4]  = '{32'h0000_0100, 32'h1022_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00FC, 1'b0};
    vecs[5]  = '{32'h0000_00FC, 32'h0800_0040, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[6]  = '{32'h0000_0100, 32'h1022_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b0};
    vecs[7]  = '{32'h0000_0104, 32'h0810_0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 1'b0};
    vecs[8]  = '{32'h0040_0000, 32'h0C00_0010, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0};
    vecs[9]  = '{32'h0000_0040, 32'h0043_1020, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 1'b0};
    vecs[10] = '{32'h0000_0044, 32'h1422_0003, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0054, 1'b0};
    vecs[11] = '{32'h0000_0054, 32'h1422_0003, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0058, 1'b0};
    vecs[12] = '{32'h0000_0058, 32'h0043_1020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_005C, 1'b1};

    reset_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678; issue_ack = 1'b0;
    clear_ctrl();
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_pc_wrap", pc2, 32'hFFFF_FFFC);

    addr_q.push_back(32'h0);
    imem_ready = 1'b0;
    reset_n = 1'b1;
    #1 check("req_at_release", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("first_req_one_cycle", 32'(imem_req), 32'd1);

    for (int i = 0; i < 13; i++) begin
      wait_req();
      check("fetch_pc", pc, vecs[i].addr);
      if (i == 0) begin
        check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        check("wrap_link0", link_addr2, 32'h0);
      end
      if (i == 1) check("wrap_addr1", imem_addr2, 32'h0);
      for (int k = 0; k < vecs[i].rdy_d; k++) begin
        imem_ready = 1'b0;
        @(negedge clk);
        check("req_hold", 32'(imem_req), 32'd1);
        check("req_hold_pc", pc, vecs[i].addr);
      end
      issue_q.push_back('{vecs[i].word, vecs[i].addr + 32'd4});
      imem_ready = 1'b1;
      imem_rdata = vecs[i].word;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = 32'hA5A5_A5A5;
      check("valid_after_ready", 32'(instr_valid), 32'd1);
      for (int k = 0; k < vecs[i].ack_d; k++) begin
        jmp = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        check("ack_hold_valid", 32'(instr_valid), 32'd1);
        check("ack_hold_instr", instr, vecs[i].word);
        check("ack_hold_pc", pc, vecs[i].addr);
      end
      jmp = 1'b0;
      imem_ready = 1'b0;
      if (vecs[i].do_rst) begin
        check("retired_before_rst", retired, 32'd12);
        imem_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(instr_valid), 32'd0);
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_retired", retired, 32'h0);
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_instr", instr, 32'h0);
        @(negedge clk);
        addr_q.push_back(32'h0);
        imem_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("req_after_rst", 32'(imem_req), 32'd1);
        @(negedge clk);
        check("no_issue_after_rst", 32'(instr_valid), 32'd0);
      end else begin
        addr_q.push_back(vecs[i].next);
        issue_ack = 1'b1;
        brn = vecs[i].brn; bne = vecs[i].bne; jmp = vecs[i].jmp;
        jal = vecs[i].jal; zero = vecs[i].zero;
        @(negedge clk);
        issue_ack = 1'b0;
        clear_ctrl();
        check("retired", retired, 32'(i + 1));
        check("next_pc", pc, vecs[i].next);
      end
    end

    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("issue_q_drained", 32'(issue_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
